t1_sim_watchdog: RTL and testbench

- Synthesizable, multi-channel successor to the testbench simulation-control loop.
- Tracks per-channel progress watchdogs, a global cycle limit, the quit/idle drain handshake and the waveform dump window.
- Reports finish or fatal with a cause code, so the bench only acts on its outputs.
- Sits in the testbench top beside the DUT; progress channels are DPI/AXI agents that kick on each transaction.

---
 rtl/t1_sim_watchdog_pkg.sv | 38 +++
 rtl/t1_sim_watchdog_ch.sv | 38 +++
 rtl/t1_sim_watchdog.sv | 172 +++++++++++++++++
 tb/tb_t1_sim_watchdog.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/t1_sim_watchdog_pkg.sv
// Shared types and helpers for the simulation watchdog.
// Counters wider than MAX_CNT_W are not supported by the helpers below.
package t1_sim_watchdog_pkg;

    typedef enum logic [2:0] {
        CFG   = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        FAIL  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_WDOG    = 2'd1,
        CAUSE_GLOBAL  = 2'd2,
        CAUSE_IDLE_TO = 2'd3
    } cause_e;

    localparam int unsigned MAX_CNT_W = 64;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                     input int unsigned          w);
        logic [MAX_CNT_W:0]   one_sh;
        logic [MAX_CNT_W-1:0] mask;
        one_sh = (MAX_CNT_W+1)'(1) << w;
        mask   = MAX_CNT_W'(one_sh - (MAX_CNT_W+1)'(1));
        return (v == mask) ? v : v + MAX_CNT_W'(1);
    endfunction

    function automatic logic in_window(input logic [MAX_CNT_W-1:0] cyc,
                                       input logic [MAX_CNT_W-1:0] start,
                                       input logic [MAX_CNT_W-1:0] stop);
        return (cyc >= start) && ((stop == '0) || (cyc < stop));
    endfunction

endpackage

// File: rtl/t1_sim_watchdog_ch.sv
// One progress channel: counts consecutive unkicked active RUN cycles
// and flags expiry on the edge that would reach the timeout.
module t1_sim_watchdog_ch
    import t1_sim_watchdog_pkg::*;
#(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_i,
    input  logic             active_i,
    input  logic             kick_i,
    input  logic [CNT_W-1:0] timeout_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_p1;

    assign cnt_p1 = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (run_i) begin
            if (kick_i || !active_i) cnt_d = '0;
            else                     cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire_o = run_i && active_i && !kick_i && (timeout_i != '0) &&
                      (cnt_p1 >= {1'b0, timeout_i});

endmodule

// File: rtl/t1_sim_watchdog.sv
// Simulation-control watchdog: per-channel progress timeouts, global cycle
// limit, quit/idle drain handshake and waveform dump window.
module t1_sim_watchdog
    import t1_sim_watchdog_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 64,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [CNT_W-1:0]  cfg_global_timeout,
    input  logic [CNT_W-1:0]  cfg_ch_timeout,
    input  logic [CNT_W-1:0]  cfg_quit_timeout,
    input  logic [CNT_W-1:0]  cfg_dump_start,
    input  logic [CNT_W-1:0]  cfg_dump_end,
    input  logic [NUM_CH-1:0] ch_active,
    input  logic [NUM_CH-1:0] ch_kick,
    input  logic              quit_req,
    input  logic              idle,
    output logic [CNT_W-1:0]  cycle,
    output logic              running,
    output logic              finish,
    output logic              fatal,
    output logic [1:0]        fatal_cause,
    output logic [CH_W-1:0]   fatal_ch,
    output logic              dump_en
);

    state_e           state_q, state_d;
    cause_e           cause_q, cause_d;
    logic [CH_W-1:0]  fch_q, fch_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             dump_q, dump_d;

    logic [CNT_W-1:0] cfg_global_q, cfg_ch_q, cfg_quit_q, cfg_dstart_q, cfg_dend_q;
    logic             cfg_ld;

    logic [NUM_CH-1:0] expire;
    logic              wd_hit;
    logic [CH_W-1:0]   wd_ch;
    logic [CNT_W-1:0]  next_cycle;
    logic [CNT_W:0]    cycle_p1, dcnt_p1;
    logic              glob_hit, idle_to_hit, in_run;

    assign in_run = (state_q == RUN);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        t1_sim_watchdog_ch #(.CNT_W(CNT_W)) u_ch (
            .clock     (clock),
            .reset     (reset),
            .run_i     (in_run),
            .active_i  (ch_active[g]),
            .kick_i    (ch_kick[g]),
            .timeout_i (cfg_ch_q),
            .expire_o  (expire[g])
        );
    end

    // Descending scan so the lowest expiring channel wins.
    always_comb begin
        wd_hit = |expire;
        wd_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (expire[i]) wd_ch = CH_W'(i);
        end
    end

    assign next_cycle  = CNT_W'(sat_inc(MAX_CNT_W'(cycle_q), CNT_W));
    assign cycle_p1    = {1'b0, cycle_q} + (CNT_W+1)'(1);
    assign dcnt_p1     = {1'b0, dcnt_q} + (CNT_W+1)'(1);
    assign glob_hit    = (cfg_global_q != '0) && (cycle_p1 == {1'b0, cfg_global_q});
    assign idle_to_hit = (cfg_quit_q != '0) && (dcnt_p1 >= {1'b0, cfg_quit_q});
    assign cfg_ld      = (state_q == CFG) && cfg_valid;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        fch_d   = fch_q;
        cycle_d = cycle_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            CFG: begin
                if (cfg_valid) state_d = RUN;
            end
            RUN: begin
                cycle_d = next_cycle;
                if (wd_hit) begin
                    state_d = FAIL;
                    cause_d = CAUSE_WDOG;
                    fch_d   = wd_ch;
                end else if (glob_hit) begin
                    state_d = FAIL;
                    cause_d = CAUSE_GLOBAL;
                end else if (quit_req) begin
                    state_d = idle ? DONE : DRAIN;
                    dcnt_d  = '0;
                end
            end
            DRAIN: begin
                cycle_d = next_cycle;
                if (idle) begin
                    state_d = DONE;
                end else begin
                    dcnt_d = CNT_W'(sat_inc(MAX_CNT_W'(dcnt_q), CNT_W));
                    if (glob_hit) begin
                        state_d = FAIL;
                        cause_d = CAUSE_GLOBAL;
                    end else if (idle_to_hit) begin
                        state_d = FAIL;
                        cause_d = CAUSE_IDLE_TO;
                    end
                end
            end
            default: ;
        endcase
    end

    // On the CFG->RUN edge the window uses the values being latched.
    always_comb begin
        dump_d = 1'b0;
        if (state_d == RUN || state_d == DRAIN) begin
            if (state_q == CFG)
                dump_d = in_window(MAX_CNT_W'(cycle_d), MAX_CNT_W'(cfg_dump_start),
                                   MAX_CNT_W'(cfg_dump_end));
            else
                dump_d = in_window(MAX_CNT_W'(cycle_d), MAX_CNT_W'(cfg_dstart_q),
                                   MAX_CNT_W'(cfg_dend_q));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= CFG;
            cause_q      <= CAUSE_NONE;
            fch_q        <= '0;
            cycle_q      <= '0;
            dcnt_q       <= '0;
            dump_q       <= 1'b0;
            cfg_global_q <= '0;
            cfg_ch_q     <= '0;
            cfg_quit_q   <= '0;
            cfg_dstart_q <= '0;
            cfg_dend_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            fch_q   <= fch_d;
            cycle_q <= cycle_d;
            dcnt_q  <= dcnt_d;
            dump_q  <= dump_d;
            if (cfg_ld) begin
                cfg_global_q <= cfg_global_timeout;
                cfg_ch_q     <= cfg_ch_timeout;
                cfg_quit_q   <= cfg_quit_timeout;
                cfg_dstart_q <= cfg_dump_start;
                cfg_dend_q   <= cfg_dump_end;
            end
        end
    end

    assign cycle       = cycle_q;
    assign running     = (state_q == RUN) || (state_q == DRAIN);
    assign finish      = (state_q == DONE);
    assign fatal       = (state_q == FAIL);
    assign fatal_cause = cause_q;
    assign fatal_ch    = fch_q;
    assign dump_en     = dump_q;

endmodule

// File: tb/tb_t1_sim_watchdog.sv
// Self-checking bench: scenario table run through a scoreboard queue, plus
// hand sequences for kicks, dump window, drain/idle, cfg lockout and reset.
module tb_t1_sim_watchdog;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [CNT_W-1:0]  cfg_global_timeout = '0, cfg_ch_timeout = '0, cfg_quit_timeout = '0;
    logic [CNT_W-1:0]  cfg_dump_start = '0, cfg_dump_end = '0;
    logic [NUM_CH-1:0] ch_active = '0, ch_kick = '0;
    logic              quit_req = 1'b0, idle = 1'b0;
    logic [CNT_W-1:0]  cycle;
    logic              running, finish, fatal, dump_en;
    logic [1:0]        fatal_cause;
    logic [1:0]        fatal_ch;

    t1_sim_watchdog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid),
        .cfg_global_timeout(cfg_global_timeout), .cfg_ch_timeout(cfg_ch_timeout),
        .cfg_quit_timeout(cfg_quit_timeout), .cfg_dump_start(cfg_dump_start),
        .cfg_dump_end(cfg_dump_end), .ch_active(ch_active), .ch_kick(ch_kick),
        .quit_req(quit_req), .idle(idle), .cycle(cycle), .running(running),
        .finish(finish), .fatal(fatal), .fatal_cause(fatal_cause),
        .fatal_ch(fatal_ch), .dump_en(dump_en)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [63:0] g, ct, qt;
        logic [3:0]  act, kick;
        logic        quit, idl;
        int          n;
        logic        e_fatal, e_finish;
        logic [1:0]  e_cause, e_ch;
        logic [63:0] e_cycle;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t mk(string nm, logic [63:0] g, logic [63:0] ct, logic [63:0] qt,
                                logic [3:0] act, logic [3:0] kick, logic quit, logic idl, int n,
                                logic ef, logic efin, logic [1:0] ec, logic [1:0] ech,
                                logic [63:0] ecyc);
        vec_t v;
        v.name = nm; v.g = g; v.ct = ct; v.qt = qt; v.act = act; v.kick = kick;
        v.quit = quit; v.idl = idl; v.n = n; v.e_fatal = ef; v.e_finish = efin;
        v.e_cause = ec; v.e_ch = ech; v.e_cycle = ecyc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        cfg_valid = 0; cfg_global_timeout = '0; cfg_ch_timeout = '0; cfg_quit_timeout = '0;
        cfg_dump_start = '0; cfg_dump_end = '0; ch_active = '0; ch_kick = '0;
        quit_req = 0; idle = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cycle"},   cycle, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_finish"},  finish, 0);
        chk({tag, "_fatal"},   fatal, 0);
        chk({tag, "_cause"},   fatal_cause, 0);
        chk({tag, "_ch"},      fatal_ch, 0);
        chk({tag, "_dump"},    dump_en, 0);
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // One edge with cfg_valid high moves CFG -> RUN with cycle still 0.
    task automatic configure(input logic [63:0] g, input logic [63:0] ct, input logic [63:0] qt,
                             input logic [63:0] ds, input logic [63:0] de);
        cfg_global_timeout = g; cfg_ch_timeout = ct; cfg_quit_timeout = qt;
        cfg_dump_start = ds; cfg_dump_end = de; cfg_valid = 1;
        tick();
        cfg_valid = 0;
    endtask

    initial begin
        vec_t v, e;
        logic exp_run;

        vecs.push_back(mk("wdog_ch0",      0, 3, 0, 4'b0001, 4'b0000, 0, 0, 3,  1, 0, 1, 0, 3));
        vecs.push_back(mk("global5",       5, 0, 0, 4'b0000, 4'b0000, 0, 0, 5,  1, 0, 2, 0, 5));
        vecs.push_back(mk("ch1_ch3_same",  0, 4, 0, 4'b1010, 4'b0000, 0, 0, 4,  1, 0, 1, 1, 4));
        vecs.push_back(mk("kick_ch0_only", 0, 2, 0, 4'b1111, 4'b0001, 0, 0, 2,  1, 0, 1, 1, 2));
        vecs.push_back(mk("quit_idle",     0, 0, 0, 4'b0000, 4'b0000, 1, 1, 1,  0, 1, 0, 0, 1));
        vecs.push_back(mk("wdog_vs_quit",  0, 1, 0, 4'b0001, 4'b0000, 1, 1, 1,  1, 0, 1, 0, 1));
        vecs.push_back(mk("glob_vs_quit",  1, 0, 0, 4'b0000, 4'b0000, 1, 1, 1,  1, 0, 2, 0, 1));
        vecs.push_back(mk("wdog_vs_glob",  3, 3, 0, 4'b0001, 4'b0000, 0, 0, 3,  1, 0, 1, 0, 3));
        vecs.push_back(mk("kept_alive",    0, 1, 0, 4'b0001, 4'b0001, 0, 0, 10, 0, 0, 0, 0, 10));
        vecs.push_back(mk("drain_to",      0, 0, 4, 4'b0000, 4'b0000, 1, 0, 5,  1, 0, 3, 0, 5));
        vecs.push_back(mk("drain_forever", 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 20, 0, 0, 0, 0, 20));
        vecs.push_back(mk("drain_glob",    3, 0, 4, 4'b0000, 4'b0000, 1, 0, 3,  1, 0, 2, 0, 3));
        vecs.push_back(mk("glob_vs_idleto",5, 0, 4, 4'b0000, 4'b0000, 1, 0, 5,  1, 0, 2, 0, 5));

        // Reset state straight out of power-on reset.
        #1;
        check_reset_outputs("por");
        tick();
        reset = 0;

        foreach (vecs[k]) begin
            v = vecs[k];
            apply_reset();
            configure(v.g, v.ct, v.qt, 0, 0);
            ch_active = v.act; ch_kick = v.kick; quit_req = v.quit; idle = v.idl;
            exp_q.push_back(v);
            repeat (v.n) tick();
            e = exp_q.pop_front();
            exp_run = !e.e_fatal && !e.e_finish;
            chk({e.name, "_fatal"},   fatal, e.e_fatal);
            chk({e.name, "_finish"},  finish, e.e_finish);
            chk({e.name, "_cause"},   fatal_cause, e.e_cause);
            chk({e.name, "_ch"},      fatal_ch, e.e_ch);
            chk({e.name, "_cycle"},   cycle, e.e_cycle);
            chk({e.name, "_running"}, running, exp_run);
            chk({e.name, "_dump"},    dump_en, exp_run);
        end

        // Kicks every 2nd cycle keep ch0 alive; dump window open from cycle 3, never closed.
        apply_reset();
        configure(0, 3, 0, 3, 0);
        ch_active = 4'b0001;
        for (int k = 0; k < 100; k++) begin
            ch_kick = (k % 2 == 1) ? 4'b0001 : 4'b0000;
            tick();
            chk("kick_dump_open", dump_en, (k + 1) >= 3);
            if (fatal) chk("kick_alive", fatal, 0);
        end
        ch_kick = 0; quit_req = 1; idle = 1;
        tick();
        quit_req = 0;
        chk("kick_finish", finish, 1);
        chk("kick_fatal",  fatal, 0);
        chk("kick_cycle",  cycle, 101);
        chk("kick_dump_off", dump_en, 0);

        // Dump window 2..5.
        apply_reset();
        configure(0, 0, 0, 2, 6);
        chk("win_c0", dump_en, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("win_cycle", cycle, k);
            chk("win_dump",  dump_en, (k >= 2) && (k < 6));
        end

        // Idle rises on the 2nd DRAIN cycle, same edge as the global limit: idle wins.
        apply_reset();
        configure(3, 0, 4, 0, 0);
        quit_req = 1; idle = 0;
        tick();
        quit_req = 0;
        chk("drain_enter_run", running, 1);
        tick();
        idle = 1;
        tick();
        chk("drain_idle_finish", finish, 1);
        chk("drain_idle_fatal",  fatal, 0);
        chk("drain_idle_cycle",  cycle, 3);

        // cfg_valid in RUN is ignored: limit 5 stays, not 2.
        apply_reset();
        configure(5, 0, 0, 0, 0);
        cfg_global_timeout = 2; cfg_valid = 1;
        tick();
        cfg_valid = 0;
        tick();
        chk("cfglock_nofatal", fatal, 0);
        repeat (3) tick();
        chk("cfglock_fatal", fatal, 1);
        chk("cfglock_cause", fatal_cause, 2);
        chk("cfglock_cycle", cycle, 5);

        // Asynchronous reset mid-DRAIN.
        apply_reset();
        configure(0, 0, 0, 0, 0);
        quit_req = 1; idle = 0;
        tick();
        quit_req = 0;
        repeat (3) tick();
        chk("mid_running", running, 1);
        chk("mid_cycle", cycle, 4);
        #2 reset = 1;
        #1;
        check_reset_outputs("async");
        tick();
        reset = 0;
        tick();
        chk("after_rst_cfg_hold", cycle, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
